// File: rtl/ps2_event_rx.sv
// PS/2 Set-2 scan-code receiver: synchronizes and filters the PS/2 pair, frames bytes,
// folds E0/F0 prefixes into {ext, release, code} events and buffers them in a FWFT FIFO.
module ps2_event_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          ps2Clk,
    input  logic                          ps2Data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_release,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_REL = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers; bit 0 is the PS/2 clock, bit 1 the data.
    // ------------------------------------------------------------------
    logic [1:0] pin_in;
    logic [1:0] pin_sync;

    assign pin_in = {ps2Data, ps2Clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic stable_reg;

            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    meta_reg   <= 1'b1;
                    stable_reg <= 1'b1;
                end else begin
                    meta_reg   <= pin_in[gi];
                    stable_reg <= meta_reg;
                end
            end

            assign pin_sync[gi] = stable_reg;
        end
    endgenerate

    logic clk_sync;
    logic data_sync;

    assign clk_sync  = pin_sync[0];
    assign data_sync = pin_sync[1];

    // ------------------------------------------------------------------
    // Clock filter: the filtered level only follows after FILTER_LEN
    // consecutive samples that disagree with it.
    // ------------------------------------------------------------------
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_clk_reg;
    logic          filt_flip;
    logic          sample_pt;

    assign filt_flip = (clk_sync != filt_clk_reg) && (filt_cnt_reg == FILT_MAX);
    assign sample_pt = filt_flip && filt_clk_reg;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            filt_cnt_reg <= '0;
            filt_clk_reg <= 1'b1;
        end else if (clk_sync == filt_clk_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_flip) begin
            filt_cnt_reg <= '0;
            filt_clk_reg <= clk_sync;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_reg;
    state_t        state_next;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          parity_reg;
    logic [TW-1:0] tout_cnt_reg;
    logic          timeout;

    assign timeout = (state_reg != IDLE) && (tout_cnt_reg == TOUT_MAX);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (timeout) begin
            state_next = IDLE;
        end else if (sample_pt) begin
            case (state_reg)
                IDLE:    if (!data_sync) state_next = DATA;
                DATA:    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    logic bit_clr;
    logic shift_en;
    logic parity_en;
    logic byte_good;
    logic err_now;

    always_comb begin
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        parity_en = 1'b0;
        byte_good = 1'b0;
        err_now   = 1'b0;
        if (timeout) begin
            err_now = 1'b1;
        end else if (sample_pt) begin
            case (state_reg)
                IDLE:    bit_clr   = !data_sync;
                DATA:    shift_en  = 1'b1;
                PARITY:  parity_en = 1'b1;
                STOP: begin
                    // Odd parity across the eight data bits plus the parity bit.
                    if (data_sync && ((^shift_reg) ^ parity_reg)) byte_good = 1'b1;
                    else                                          err_now   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [7:0] rx_byte_reg;
    logic       byte_done_reg;
    logic       frame_err_reg;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            tout_cnt_reg  <= '0;
            rx_byte_reg   <= '0;
            byte_done_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            byte_done_reg <= byte_good;
            frame_err_reg <= err_now;

            if (timeout || bit_clr) begin
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
            end else if (shift_en) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                shift_reg   <= {data_sync, shift_reg[7:1]};
            end

            if (parity_en) parity_reg <= data_sync;
            if (byte_good) rx_byte_reg <= shift_reg;

            if (state_reg == IDLE || sample_pt) begin
                tout_cnt_reg <= '0;
            end else if (!timeout) begin
                tout_cnt_reg <= tout_cnt_reg + 1'b1;
            end
        end
    end

    assign frame_err = frame_err_reg;

    // ------------------------------------------------------------------
    // Prefix decode: E0/F0 only arm flags; any other byte becomes an event.
    // ------------------------------------------------------------------
    logic ext_pend_reg;
    logic rel_pend_reg;
    logic is_prefix;
    logic push_req;

    assign is_prefix = (rx_byte_reg == CODE_EXT) || (rx_byte_reg == CODE_REL);
    assign push_req  = byte_done_reg && !is_prefix;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ext_pend_reg <= 1'b0;
            rel_pend_reg <= 1'b0;
        end else if (frame_err_reg) begin
            ext_pend_reg <= 1'b0;
            rel_pend_reg <= 1'b0;
        end else if (byte_done_reg) begin
            if (rx_byte_reg == CODE_EXT) begin
                ext_pend_reg <= 1'b1;
            end else if (rx_byte_reg == CODE_REL) begin
                rel_pend_reg <= 1'b1;
            end else begin
                ext_pend_reg <= 1'b0;
                rel_pend_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word fall-through event FIFO, entry = {ext, release, code}.
    // ------------------------------------------------------------------
    logic [9:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [9:0]    head;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full    = (count_reg == FULL_CNT);
    assign pop     = ev_valid && ev_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= {ext_pend_reg, rel_pend_reg, rx_byte_reg};
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    assign head       = fifo_mem[rd_ptr_reg];
    assign ev_valid   = (count_reg != '0);
    assign ev_code    = ev_valid ? head[7:0] : 8'h00;
    assign ev_release = ev_valid && head[8];
    assign ev_ext     = ev_valid && head[9];
    assign overflow   = push_req && full && !pop;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_ps2_event_rx.sv
// Directed bench for ps2_event_rx: drives PS/2 frames, scoreboards the event stream
// and tracks frame_err / overflow / ev_valid cycle counts.
module tb_ps2_event_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int FIFO_DEPTH = 4;
    localparam int HALF       = 25;

    logic       clk;
    logic       n_reset;
    logic       ps2Clk;
    logic       ps2Data;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;

    ps2_event_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_release (ev_release),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    int         err_cycles = 0;
    int         ovf_cycles = 0;
    int         val_cycles = 0;
    logic [9:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor samples on the falling edge; stimulus changes just after the rising edge.
    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] exp;
        if (frame_err) err_cycles++;
        if (overflow)  ovf_cycles++;
        if (ev_valid)  val_cycles++;
        if (ev_valid && ev_ready) begin
            got = {ev_ext, ev_release, ev_code};
            compared++;
            assert (sb.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_event: observed %03h expected no event", got);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("event", 32'(got), 32'(exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2Data = b;
        tick(HALF);
        ps2Clk = 1'b0;
        tick(HALF);
        ps2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(stop);
        ps2Data = 1'b1;
        tick(60);
    endtask

    task automatic expect_ev(input logic ext, input logic rel, input logic [7:0] code);
        sb.push_back({ext, rel, code});
    endtask

    int               exp_err;
    int               val_before;
    logic [7:0]       burst [4];

    initial begin
        n_reset  = 1'b0;
        ps2Clk   = 1'b1;
        ps2Data  = 1'b1;
        ev_ready = 1'b1;
        exp_err  = 0;
        tick(5);
        check("reset_valid", 32'(ev_valid), 0);
        check("reset_count", 32'(fifo_count), 0);
        check("reset_code", 32'(ev_code), 0);
        check("reset_err", 32'(frame_err), 0);
        check("reset_ovf", 32'(overflow), 0);
        n_reset = 1'b1;
        tick(20);

        // Make code 0x1C
        expect_ev(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("make_valid_cycles", 32'(val_cycles), 1);
        check("make_sb_empty", 32'(sb.size()), 0);
        check("make_no_err", 32'(err_cycles), 0);

        // Prefixes
        expect_ev(1'b0, 1'b1, 8'h1C);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        expect_ev(1'b1, 1'b1, 8'h74);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        check("prefix_valid_cycles", 32'(val_cycles), 3);
        check("prefix_sb_empty", 32'(sb.size()), 0);

        // Parity error
        val_before = val_cycles;
        send_frame(8'h1C, 1'b1, 1'b1);
        exp_err++;
        check("parity_err_cycles", 32'(err_cycles), 32'(exp_err));
        check("parity_no_event", 32'(val_cycles), 32'(val_before));

        // E0 then a stop-bit error clears the pending ext flag
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0);
        exp_err++;
        expect_ev(1'b0, 1'b0, 8'h75);
        send_frame(8'h75, 1'b0, 1'b1);
        check("stop_err_cycles", 32'(err_cycles), 32'(exp_err));
        check("stop_sb_empty", 32'(sb.size()), 0);

        // Timeout mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2Data = 1'b1;
        tick(TIMEOUT + 50);
        exp_err++;
        check("timeout_err_cycles", 32'(err_cycles), 32'(exp_err));
        expect_ev(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("timeout_recover_sb", 32'(sb.size()), 0);

        // FIFO full and overflow
        ev_ready = 1'b0;
        burst[0] = 8'h15;
        burst[1] = 8'h16;
        burst[2] = 8'h17;
        burst[3] = 8'h18;
        for (int i = 0; i < 4; i++) begin
            expect_ev(1'b0, 1'b0, burst[i]);
            send_frame(burst[i], 1'b0, 1'b1);
        end
        check("full_no_ovf_yet", 32'(ovf_cycles), 0);
        send_frame(8'h19, 1'b0, 1'b1);
        check("full_count", 32'(fifo_count), 4);
        check("full_ovf_cycles", 32'(ovf_cycles), 1);
        check("full_head", 32'(ev_code), 32'h15);
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_valid", 32'(ev_valid), 1);
            check("drain_code", 32'(ev_code), 32'(burst[i]));
        end
        @(negedge clk);
        check("drain_empty_valid", 32'(ev_valid), 0);
        check("drain_empty_code", 32'(ev_code), 0);
        tick(5);
        check("drain_sb_empty", 32'(sb.size()), 0);

        // Glitches shorter than the filter must not sample any bit
        val_before = val_cycles;
        ps2Data = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2Clk = 1'b0;
            tick(FILTER_LEN - 1);
            ps2Clk = 1'b1;
            tick(20);
        end
        ps2Data = 1'b1;
        tick(TIMEOUT + 50);
        check("glitch_no_err", 32'(err_cycles), 32'(exp_err));
        check("glitch_no_event", 32'(val_cycles), 32'(val_before));
        expect_ev(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("glitch_recover_sb", 32'(sb.size()), 0);

        // Reset with two buffered events and a partial frame in flight
        ev_ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1);
        check("prereset_count", 32'(fifo_count), 2);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        n_reset = 1'b0;
        #1;
        check("rst_count", 32'(fifo_count), 0);
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_code", 32'(ev_code), 0);
        check("rst_ext_rel", 32'({ev_ext, ev_release}), 0);
        check("rst_err_ovf", 32'({frame_err, overflow}), 0);
        ps2Data = 1'b1;
        tick(3);
        n_reset = 1'b1;
        tick(TIMEOUT + 50);
        check("postrst_no_err", 32'(err_cycles), 32'(exp_err));
        ev_ready = 1'b1;
        expect_ev(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("postrst_sb_empty", 32'(sb.size()), 0);
        check("final_err_cycles", 32'(err_cycles), 32'(exp_err));
        check("final_ovf_cycles", 32'(ovf_cycles), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
